// File: rtl/sdram_port_scheduler.sv
// Burst scheduler for the 4-port SDRAM frame buffer: per-port address tracking, arbitration, request hold.
// Define SDRAM_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2 > 3.

module sdram_sched_port #(
    parameter int ASIZE = 22,
    parameter int LSIZE = 9,
    parameter int LVLW  = 16,
    parameter bit IS_WR = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [ASIZE-1:0] start_addr_i,
    input  logic [ASIZE-1:0] max_addr_i,
    input  logic [LSIZE-1:0] length_i,
    input  logic [LVLW-1:0]  lvl_i,
    output logic             elig_o,
    output logic [ASIZE-1:0] cur_addr_o,
    output logic [LSIZE-1:0] len_o
);
    logic [ASIZE-1:0] cur_addr_q, cur_addr_d, len_a;
    logic [LSIZE-1:0] len_q, len_d;
    logic [LVLW-1:0]  len_l;

    assign len_a = ASIZE'(len_q);
    assign len_l = LVLW'(len_q);

    // Reads want room for a whole burst; writes want a whole burst buffered.
    assign elig_o = (len_q != '0) && (IS_WR ? (lvl_i >= len_l) : (lvl_i < len_l));

    always_comb begin
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        if (load_i) begin
            cur_addr_d = start_addr_i;
            len_d      = length_i;
        end else if (adv_i) begin
            if (cur_addr_q < max_addr_i - len_a)
                cur_addr_d = cur_addr_q + len_a;
            else
                cur_addr_d = start_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cur_addr_q <= start_addr_i;
            len_q      <= length_i;
        end else begin
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
        end
    end

    assign cur_addr_o = cur_addr_q;
    assign len_o      = len_q;
endmodule

module sdram_port_scheduler #(
    parameter int ASIZE = 22,
    parameter int LSIZE = 9,
    parameter int LVLW  = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [3:0]         load_i,
    input  logic [4*ASIZE-1:0] start_addr_i,
    input  logic [4*ASIZE-1:0] max_addr_i,
    input  logic [4*LSIZE-1:0] length_i,
    input  logic [2*LVLW-1:0]  rd_lvl_i,
    input  logic [2*LVLW-1:0]  wr_lvl_i,
    input  logic               seq_idle_i,
    input  logic               done_i,
    output logic               req_rd_o,
    output logic               req_wr_o,
    output logic [ASIZE-1:0]   req_addr_o,
    output logic [LSIZE-1:0]   req_len_o,
    output logic [3:0]         gnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic                    req_rd_q, req_rd_d, req_wr_q, req_wr_d;
    logic [ASIZE-1:0]        req_addr_q, req_addr_d;
    logic [LSIZE-1:0]        req_len_q, req_len_d;
    logic [3:0]              gnt_q, gnt_d;
    logic                    load_seen_q, load_seen_d;
    logic [3:0][ASIZE-1:0]   cur_addr;
    logic [3:0][LSIZE-1:0]   len;
    logic [3:0][LVLW-1:0]    lvl;
    logic [3:0]              elig, adv, win;
    logic [ASIZE-1:0]        win_addr;
    logic [LSIZE-1:0]        win_len;
    logic [1:0]              idx;
    logic                    found, grant;

    for (genvar i = 0; i < 4; i++) begin : g_port
        if (i < 2) begin : g_rd
            assign lvl[i] = rd_lvl_i[i*LVLW +: LVLW];
        end else begin : g_wr
            assign lvl[i] = wr_lvl_i[(i-2)*LVLW +: LVLW];
        end
        sdram_sched_port #(.ASIZE(ASIZE), .LSIZE(LSIZE), .LVLW(LVLW), .IS_WR(i >= 2)) u_port (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .load_i       (load_i[i]),
            .adv_i        (adv[i]),
            .start_addr_i (start_addr_i[i*ASIZE +: ASIZE]),
            .max_addr_i   (max_addr_i[i*ASIZE +: ASIZE]),
            .length_i     (length_i[i*LSIZE +: LSIZE]),
            .lvl_i        (lvl[i]),
            .elig_o       (elig[i]),
            .cur_addr_o   (cur_addr[i]),
            .len_o        (len[i])
        );
    end

`ifdef SDRAM_SCHED_RR_EN
    logic [1:0] rr_q, win_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i)    rr_q <= 2'd3;
        else if (grant) rr_q <= win_idx;
    end
`endif

    always_comb begin
        win      = '0;
        found    = 1'b0;
        idx      = '0;
        win_addr = '0;
        win_len  = '0;
`ifdef SDRAM_SCHED_RR_EN
        win_idx  = rr_q;
`endif
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_SCHED_RR_EN
            idx = rr_q + 2'd1 + 2'(k);
`else
            idx = 2'(k);
`endif
            if (!found && elig[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
                win_addr = cur_addr[idx];
                win_len  = len[idx];
`ifdef SDRAM_SCHED_RR_EN
                win_idx  = idx;
`endif
            end
        end
    end

    assign grant = (state_q == S_IDLE) && seq_idle_i && (load_i == 4'b0) && found;

    // A reload seen at any point of the burst must survive until DONE so the new address is not advanced.
    assign load_seen_d = (state_q == S_WAIT) && (load_seen_q || |(load_i & gnt_q));
    assign adv = gnt_q & {4{(state_q == S_WAIT) && done_i && !load_seen_d}};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            gnt_q       <= '0;
            load_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_rd_q    <= req_rd_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            gnt_q       <= gnt_d;
            load_seen_q <= load_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_WAIT;
            S_WAIT:  if (done_i) state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_rd_d   = req_rd_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        gnt_d      = gnt_q;
        if (grant) begin
            gnt_d      = win;
            req_addr_d = win_addr;
            req_len_d  = win_len;
            req_rd_d   = |win[1:0];
            req_wr_d   = |win[3:2];
        end else if (state_q == S_WAIT && done_i) begin
            req_rd_d = 1'b0;
            req_wr_d = 1'b0;
            gnt_d    = '0;
        end
    end

    assign req_rd_o   = req_rd_q;
    assign req_wr_o   = req_wr_q;
    assign req_addr_o = req_addr_q;
    assign req_len_o  = req_len_q;
    assign gnt_o      = gnt_q;
endmodule

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

Burst scheduler for the 4-port SDRAM frame-buffer controller. Tracks a current burst address per port, picks the next port to serve from the FIFO fill levels, and issues one read or write burst request with address and length to the SDRAM command sequencer. It then holds the request until the sequencer pulses done and advances that port's address with wrap to its start address. It sits between the port FIFOs and the SDRAM command sequencer, in the CLK domain.

## Interface
- ASIZE, 22, SDRAM word address width
- LSIZE, 9, burst length width
- LVLW, 16, FIFO used-word count width
- Port index used throughout: 0 = RD1, 1 = RD2, 2 = WR1, 3 = WR2; flattened buses place port i at bits [i*W +: W].
- CLK  in  1  controller clock (all logic on rising edge)
- RESET  in  1  synchronous, active-high reset
- LOAD  in  4  per-port load: reload the current address and length, and block new grants
- START_ADDR  in  4*ASIZE  per-port start address
- MAX_ADDR  in  4*ASIZE  per-port wrap limit
- LENGTH  in  4*LSIZE  per-port burst length
- RD_LVL  in  2*LVLW  write-side used words of read FIFOs 0,1
- WR_LVL  in  2*LVLW  read-side used words of write FIFOs 2,3
- SEQ_IDLE  in  1  sequencer is in its idle state
- DONE  in  1  one-cycle burst-complete pulse from the sequencer
- REQ_RD  out  1  read burst request
- REQ_WR  out  1  write burst request
- REQ_ADDR  out  ASIZE  burst start address
- REQ_LEN  out  LSIZE  burst length
- GNT  out  4  one-hot granted port; selects the FIFO mask and data mux

## Operation
- Per-port registers: cur_addr[i] (ASIZE bits) and len[i] (LSIZE bits). LOAD[i] sets cur_addr[i] = START_ADDR[i] and len[i] = LENGTH[i]; LOAD has priority over the DONE update.
- Eligibility:
  - Read port i: len[i] != 0 and RD_LVL[i] < len[i].
  - Write port i: len[i] != 0 and WR_LVL[i] >= len[i].
  - Comparisons are unsigned; len is zero-extended to LVLW.
- FSM, 3 states:
  - IDLE: if SEQ_IDLE, LOAD == 0, and any port is eligible, latch the winner into GNT, REQ_ADDR = cur_addr, REQ_LEN = len, and set REQ_RD or REQ_WR by port type; go to WAIT.
  - WAIT: hold all request outputs constant. On DONE, clear REQ_RD, REQ_WR and GNT, update cur_addr of the granted port, and go to HOLD.
  - HOLD: one cycle with no action, then IDLE. This lets the sequencer deassert its done state.
- Address update on DONE for granted port g: if cur_addr[g] < MAX_ADDR[g] - len[g] (ASIZE-bit subtraction), cur_addr[g] += len[g]; otherwise cur_addr[g] = START_ADDR[g]. The sum is truncated to ASIZE bits.
- LOAD[g] asserted during WAIT: the burst completes unchanged, and on DONE cur_addr[g] keeps the loaded value (no advance).
- DONE outside WAIT: ignored.
- Reset: state IDLE, REQ_RD = 0, REQ_WR = 0, REQ_ADDR = 0, REQ_LEN = 0, GNT = 0, cur_addr[i] = START_ADDR[i], len[i] = LENGTH[i], round-robin pointer = 3.
- RESET mid-burst: all outputs return to reset values on the next edge; the sequencer is reset by the same signal.

## Timing
- Eligibility sampled in IDLE at edge N; REQ_* and GNT valid from edge N+1.
- DONE high at edge M: REQ_* and GNT low from M+1, updated cur_addr visible from M+1, earliest next grant at edge M+2.
- At most one grant per burst; REQ_RD and REQ_WR are never both high.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SDRAM_SCHED_RR_EN defined: round-robin arbitration. The search starts at (last_granted + 1) mod 4, wrapping 3 to 0. The pointer updates at grant.
- Not defined: fixed priority 0 > 1 > 2 > 3 (reads before writes); the pointer register is not built.

## Test plan
- Reset with START_ADDR[0] = 0x002080, LENGTH[0] = 128, RD_LVL[0] = 0, SEQ_IDLE = 1 -> REQ_RD = 1, REQ_ADDR = 0x002080, REQ_LEN = 128, GNT = 4'b0001 two edges after RESET falls.
- DONE pulse in WAIT with cur_addr[0] = 0x002080, MAX = 0x027880 -> REQ_RD = 0 next edge; next grant of port 0 shows REQ_ADDR = 0x002100.
- Wrap: cur_addr[2] = 0x059F80, len = 128, MAX = 0x05A000, WR_LVL[0] = 200 -> after DONE, the next port-2 request has REQ_ADDR = START_ADDR[2].
- All four ports eligible continuously, DONE after each grant -> with _EN the GNT sequence is 1, 2, 4, 8, 1; without it, GNT stays 4'b0001.
- LOAD[2] pulsed during a port-2 WAIT with START_ADDR[2] = 0x100000 -> the burst completes, and the following port-2 request has REQ_ADDR = 0x100000. Separately, LOAD held high in IDLE -> no grant while high.
- len[3] = 0 with WR_LVL[1] = 500, all other ports ineligible -> no request is ever issued.
